dspmac_fir_seq_16_40: RTL and testbench

- Sequencer that drives an external 16x16 -> 40-bit MAC unit to form a TAPS-tap FIR filter.
- The MAC has a 2-bit opcode: 00 CLR, 01 MUL, 10 MAC, 11 NOP. It registers its accumulator on the clock edge that samples the opcode.
- This block owns the sample delay line and the coefficient registers, and issues the opcode/operand stream into the MAC.
- It reads the 40-bit accumulator back, rounds and saturates it to 16 bits, and delivers results on a valid/ready stream.

---
 rtl/dspmac_fir_seq_16_40.sv | 198 +++++++++++++++++++
 tb/tb_dspmac_fir_seq_16_40.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dspmac_fir_seq_16_40.sv
// ---------------------------------------------------------------------------
// dspmac_fir_seq_16_40
//
// Sequencer that turns an external 16x16 -> 40-bit MAC into a TAPS-tap FIR
// filter. This block owns the sample delay line and the coefficient bank,
// streams (opcode, sample, coefficient) into the MAC one tap per cycle, then
// reads the accumulator back, rounds half-up, shifts by SHIFT and saturates
// it to a signed 16-bit result delivered on a valid/ready stream.
//
// Ports
//   clk, rst_n          rising-edge clock, async active-low reset (shared
//                       with the MAC)
//   coef_we/addr/data   coefficient write port, honoured only while idle
//   s_valid/ready/data  input sample stream
//   mac_opcode/a/b      operand stream to the MAC (00 CLR, 01 MUL, 10 MAC,
//                       11 NOP); decoded from registered state only
//   mac_accu            40-bit signed accumulator returned by the MAC
//   m_valid/ready/data  filtered output stream
//   m_sat               m_data was clipped; qualified by m_valid
//   busy                high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module dspmac_fir_seq_16_40 #(
  parameter int TAPS  = 8,
  parameter int SHIFT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        coef_we,
  input  logic [3:0]  coef_addr,
  input  logic [15:0] coef_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic [1:0]  mac_opcode,
  output logic [15:0] mac_a,
  output logic [15:0] mac_b,
  input  logic [39:0] mac_accu,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        m_sat,
  output logic        busy
);

  localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [KW-1:0] K_LAST   = KW'(TAPS - 1);
  localparam logic [4:0]    TAPS_LIM = 5'(TAPS);
  localparam logic signed [40:0] RND = 41'sd1 <<< (SHIFT - 1);
  localparam logic signed [40:0] Q_MAX = 41'sd32767;
  localparam logic signed [40:0] Q_MIN = -41'sd32768;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_OUT
  } state_e;

  typedef enum logic [1:0] {
    OP_CLR = 2'b00,
    OP_MUL = 2'b01,
    OP_MAC = 2'b10,
    OP_NOP = 2'b11
  } op_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [15:0]   x_q [TAPS];
  logic [15:0]   h_q [TAPS];
  logic          m_valid_q, m_valid_d;
  logic [15:0]   m_data_q, m_data_d;
  logic          m_sat_q, m_sat_d;
  logic          shift_en;
  logic          coef_wr_en;
  op_e           op;

  // Quantizer: round half-up by adding 2^(SHIFT-1) before the arithmetic
  // shift, then clip to the signed 16-bit range.
  logic signed [40:0] acc_ext;
  logic signed [40:0] rnd_sum;
  logic signed [40:0] q_full;
  logic [15:0]        q_data;
  logic               q_sat;

  assign acc_ext = $signed({mac_accu[39], mac_accu});
  assign rnd_sum = acc_ext + RND;
  assign q_full  = rnd_sum >>> SHIFT;

  always_comb begin
    q_data = q_full[15:0];
    q_sat  = 1'b0;
    if (q_full > Q_MAX) begin
      q_data = 16'h7FFF;
      q_sat  = 1'b1;
    end else if (q_full < Q_MIN) begin
      q_data = 16'h8000;
      q_sat  = 1'b1;
    end
  end

  assign coef_wr_en = coef_we && (state_q == S_IDLE) && ({1'b0, coef_addr} < TAPS_LIM);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_sat_d   = m_sat_q;
    shift_en  = 1'b0;
    s_ready   = 1'b0;
    busy      = 1'b1;
    op        = OP_NOP;
    mac_a     = '0;
    mac_b     = '0;

    unique case (state_q)
      S_IDLE: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (s_valid) begin
          shift_en = 1'b1;
          k_d      = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        mac_a = x_q[k_q];
        mac_b = h_q[k_q];
        // MUL on the first tap overwrites the accumulator, so no CLR is issued.
        op    = (k_q == '0) ? OP_MUL : OP_MAC;
        k_d   = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        m_data_d  = q_data;
        m_sat_d   = q_sat;
        m_valid_d = 1'b1;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mac_opcode = op;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_sat      = m_sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_sat_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_sat_q   <= m_sat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
      end
    end else if (shift_en) begin
      for (int unsigned i = TAPS - 1; i > 0; i--) begin
        x_q[i] <= x_q[i-1];
      end
      x_q[0] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        h_q[i] <= '0;
      end
    end else if (coef_wr_en) begin
      h_q[coef_addr[KW-1:0]] <= coef_data;
    end
  end

endmodule

// File: tb/tb_dspmac_fir_seq_16_40.sv
module tb_dspmac_fir_seq_16_40;

  localparam int TAPS  = 8;
  localparam int SHIFT = 15;

  logic        clk;
  logic        rst_n;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [15:0] coef_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic [1:0]  mac_opcode;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic [39:0] mac_accu;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_sat;
  logic        busy;

  int nchecks = 0;
  int nerr    = 0;

  dspmac_fir_seq_16_40 #(.TAPS(TAPS), .SHIFT(SHIFT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .mac_opcode (mac_opcode),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_accu   (mac_accu),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_sat      (m_sat),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External MAC unit: registers its accumulator on the edge sampling the opcode.
  logic signed [31:0] prod;
  assign prod = $signed(mac_a) * $signed(mac_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_accu <= '0;
    end else begin
      case (mac_opcode)
        2'b00:   mac_accu <= '0;
        2'b01:   mac_accu <= {{8{prod[31]}}, prod};
        2'b10:   mac_accu <= mac_accu + {{8{prod[31]}}, prod};
        default: mac_accu <= mac_accu;
      endcase
    end
  end

  // Reference model: filter history and coefficients as plain arrays.
  logic signed [15:0] mx [TAPS];
  logic signed [15:0] mh [TAPS];

  function automatic logic [16:0] ref_out();
    longint acc = 0;
    longint q;
    for (int i = 0; i < TAPS; i++) begin
      acc += longint'(mx[i]) * longint'(mh[i]);
    end
    q = (acc + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    if (q > 32767)       return {1'b1, 16'h7FFF};
    else if (q < -32768) return {1'b1, 16'h8000};
    else                 return {1'b0, 16'(q)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wcoef(input logic [3:0] addr, input logic [15:0] data);
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = data;
    tick();
    coef_we = 1'b0;
    if (int'(addr) < TAPS) mh[addr] = data;
  endtask

  task automatic model_clear();
    for (int i = 0; i < TAPS; i++) begin
      mx[i] = '0;
      mh[i] = '0;
    end
  endtask

  // One sample through the filter; optional illegal coefficient write while
  // busy, and optional backpressure with s_valid held high.
  task automatic sample(input logic [15:0] d, input int hold, input bit bad_wr,
                        input bit bp_valid, output logic [16:0] got);
    int n;
    logic [16:0] exp;
    n = 0;
    while (!s_ready && n < 100) begin
      tick();
      n++;
    end
    check("s_ready_wait", 64'(s_ready), 64'(1));
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
    for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = d;
    exp = ref_out();
    check("run_op_first", 64'(mac_opcode), 64'(2'b01));
    check("run_a_first", 64'(mac_a), 64'(d));
    check("run_busy", 64'(busy), 64'(1));
    n = 0;
    if (bad_wr) begin
      coef_we   = 1'b1;
      coef_addr = 4'd0;
      coef_data = 16'd100;
      tick();
      coef_we = 1'b0;
      n = 1;
    end
    while (!m_valid && n < 100) begin
      tick();
      n++;
    end
    check("latency", 64'(n), 64'(TAPS + 1));
    check("m_data", 64'(m_data), 64'(exp[15:0]));
    check("m_sat", 64'(m_sat), 64'(exp[16]));
    got = {m_sat, m_data};
    if (bp_valid) begin
      s_valid = 1'b1;
      s_data  = ~d;
    end
    for (int c = 0; c < hold; c++) begin
      tick();
      check("bp_data", 64'(m_data), 64'(exp[15:0]));
      check("bp_sat", 64'(m_sat), 64'(exp[16]));
      check("bp_valid", 64'(m_valid), 64'(1));
      check("bp_s_ready", 64'(s_ready), 64'(0));
      check("bp_op_nop", 64'(mac_opcode), 64'(2'b11));
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    s_valid = 1'b0;
    check("post_m_valid", 64'(m_valid), 64'(0));
    check("post_s_ready", 64'(s_ready), 64'(1));
  endtask

  initial begin
    logic [16:0] got;
    rst_n     = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    m_ready   = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_data", 64'(m_data), 64'(0));
    check("rst_m_sat", 64'(m_sat), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_s_ready", 64'(s_ready), 64'(1));
    check("rst_op", 64'(mac_opcode), 64'(2'b11));
    check("rst_a", 64'(mac_a), 64'(0));
    check("rst_b", 64'(mac_b), 64'(0));

    // Impulse response with coefficient lockout (busy write, out-of-range write).
    wcoef(4'd0, 16'd16384);
    wcoef(4'd1, 16'd8192);
    wcoef(4'(TAPS), 16'd555);
    sample(16'd32767, 0, 1'b1, 1'b0, got);
    check("imp_0", 64'(got), 64'({1'b0, 16'd16384}));
    sample(16'd0, 1, 1'b0, 1'b0, got);
    check("imp_1", 64'(got), 64'({1'b0, 16'd8192}));
    sample(16'd0, 0, 1'b0, 1'b0, got);
    check("imp_2", 64'(got), 64'({1'b0, 16'd0}));

    // Rounding, with backpressure on the second sample.
    for (int i = 0; i < TAPS; i++) wcoef(4'(i), 16'd0);
    wcoef(4'd0, 16'd1);
    sample(16'hC000, 0, 1'b0, 1'b0, got);
    check("round_neg_half", 64'(got), 64'({1'b0, 16'd0}));
    sample(16'h4000, 20, 1'b0, 1'b1, got);
    check("round_pos_half", 64'(got), 64'({1'b0, 16'd1}));

    // Saturation at both rails.
    for (int i = 0; i < TAPS; i++) wcoef(4'(i), 16'd32767);
    for (int i = 0; i < 8; i++) sample(16'h7FFF, 0, 1'b0, 1'b0, got);
    check("sat_pos", 64'(got), 64'({1'b1, 16'h7FFF}));
    for (int i = 0; i < 8; i++) sample(16'h8000, 0, 1'b0, 1'b0, got);
    check("sat_neg", 64'(got), 64'({1'b1, 16'h8000}));

    // Randomised coefficients, samples and backpressure.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < 3; j++) wcoef(4'($urandom_range(0, 15)), 16'($urandom));
      end
      sample(16'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)), got);
    end

    // Reset in the middle of RUN at k=3.
    s_valid = 1'b1;
    s_data  = 16'h1234;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    tick();
    check("pre_rst_op", 64'(mac_opcode), 64'(2'b10));
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 64'(busy), 64'(0));
    check("mrst_op", 64'(mac_opcode), 64'(2'b11));
    check("mrst_m_valid", 64'(m_valid), 64'(0));
    #3;
    rst_n = 1'b1;
    model_clear();
    tick();
    check("mrst_no_valid", 64'(m_valid), 64'(0));
    sample(16'd32767, 0, 1'b0, 1'b0, got);
    check("mrst_impulse", 64'(got), 64'({1'b0, 16'd0}));

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
